// File: rtl/seq_overlap_trimmer_pkg.sv
// Shared widths and types for the sequence overlap trimmer.
//   SEQ_LL_BITS       literal-length field width
//   SEQ_ML_BITS       match-length / overlap-length field width
//   SEQ_OFFSET_BITS   match offset field width
//   SEQ_DROP_CNT_BITS swallowed-sequence counter width
package seq_overlap_trimmer_pkg;

  localparam int SEQ_LL_BITS       = 12;
  localparam int SEQ_ML_BITS       = 16;
  localparam int SEQ_OFFSET_BITS   = 20;
  localparam int SEQ_DROP_CNT_BITS = 16;

  typedef enum logic {
    ST_PASS = 1'b0,   // skip budget is zero, sequences forwarded untouched
    ST_TRIM = 1'b1    // skip budget pending, head bytes are being removed
  } trim_state_e;

  function automatic int max_w(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seq_overlap_trimmer_if.sv
// Sequence stream bus with valid/ready flow control.
//   valid/ready  handshake, transfer when both high
//   ll, ml       literal and match lengths
//   offset       match offset
//   eoj          last sequence of a job
//   overlap_len  bytes of the next job already covered (only with eoj)
//   delim        block delimiter
// master drives the payload, slave drives ready.
interface seq_overlap_trimmer_if #(
  parameter int LL_W  = seq_overlap_trimmer_pkg::SEQ_LL_BITS,
  parameter int ML_W  = seq_overlap_trimmer_pkg::SEQ_ML_BITS,
  parameter int OFF_W = seq_overlap_trimmer_pkg::SEQ_OFFSET_BITS
) ();

  logic             valid;
  logic             ready;
  logic [LL_W-1:0]  ll;
  logic [ML_W-1:0]  ml;
  logic [OFF_W-1:0] offset;
  logic             eoj;
  logic [ML_W-1:0]  overlap_len;
  logic             delim;

  modport master (output valid, ll, ml, offset, eoj, overlap_len, delim, input ready);
  modport slave  (input valid, ll, ml, offset, eoj, overlap_len, delim, output ready);

endinterface

// File: rtl/seq_overlap_trimmer_trim_calc.sv
// seq_trim_calc: removes a skip budget from the head of one sequence.
// Literals are consumed first, then the match; whatever budget is left
// over is returned as rem.
//   skip    in   bytes still to remove
//   ll, ml  in   literal and match length of the sequence
//   ll_out  out  trimmed literal length
//   ml_out  out  trimmed match length
//   rem     out  budget not absorbed by this sequence
module seq_trim_calc
  import seq_overlap_trimmer_pkg::*;
#(
  parameter int LL_W = SEQ_LL_BITS,
  parameter int ML_W = SEQ_ML_BITS
) (
  input  logic [ML_W-1:0] skip,
  input  logic [LL_W-1:0] ll,
  input  logic [ML_W-1:0] ml,
  output logic [LL_W-1:0] ll_out,
  output logic [ML_W-1:0] ml_out,
  output logic [ML_W-1:0] rem
);

  // ll and skip have different widths; compare at the wider of the two.
  localparam int W = max_w(LL_W, ML_W);

  typedef struct packed {
    logic [LL_W-1:0] ll;
    logic [ML_W-1:0] ml;
    logic [ML_W-1:0] rem;
  } trim_res_t;

  function automatic trim_res_t trim(input logic [ML_W-1:0] s,
                                     input logic [LL_W-1:0] l,
                                     input logic [ML_W-1:0] m);
    trim_res_t  t;
    logic [W-1:0] s_w, l_w, m_w, r_w;
    s_w = W'(s);
    l_w = W'(l);
    m_w = W'(m);
    r_w = '0;
    if (s_w <= l_w) begin
      t.ll  = LL_W'(l_w - s_w);
      t.ml  = m;
      t.rem = '0;
    end else begin
      r_w  = s_w - l_w;
      t.ll = '0;
      if (r_w < m_w) begin
        t.ml  = ML_W'(m_w - r_w);
        t.rem = '0;
      end else begin
        t.ml  = '0;
        t.rem = ML_W'(r_w - m_w);
      end
    end
    return t;
  endfunction

  trim_res_t res;

  assign res    = trim(skip, ll, ml);
  assign ll_out = res.ll;
  assign ml_out = res.ml;
  assign rem    = res.rem;

endmodule

// File: rtl/seq_overlap_trimmer.sv
// seq_overlap_trimmer: strips bytes of a job that the previous job already
// covered, so the downstream encoder sees a contiguous stream.
//   clk, rst_n   clock and synchronous active-low reset
//   in_if        upstream sequences (slave); ready = !out_valid || out_ready
//   out_if       trimmed sequences (master), one registered stage
//   overlap_err  sticky: a job ended with skip budget left over
//   drop_cnt     saturating count of sequences swallowed entirely
module seq_overlap_trimmer
  import seq_overlap_trimmer_pkg::*;
#(
  parameter int LL_W  = SEQ_LL_BITS,
  parameter int ML_W  = SEQ_ML_BITS,
  parameter int OFF_W = SEQ_OFFSET_BITS,
  parameter int CNT_W = SEQ_DROP_CNT_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seq_overlap_trimmer_if.slave  in_if,
  seq_overlap_trimmer_if.master out_if,
  output logic                  overlap_err,
  output logic [CNT_W-1:0]      drop_cnt
);

  trim_state_e     state_q, state_d;
  logic [ML_W-1:0] skip_q, skip_d;
  logic [ML_W-1:0] skip_eff;
  logic [LL_W-1:0] t_ll;
  logic [ML_W-1:0] t_ml, t_rem;
  logic            in_fire;
  logic            emit;
  logic            set_err;

  assign in_if.ready = !out_if.valid || out_if.ready;
  assign in_fire     = in_if.valid && in_if.ready;

  // The output bus carries no overlap information downstream.
  assign out_if.overlap_len = '0;

  assign skip_eff = (state_q == ST_TRIM) ? skip_q : '0;

  seq_trim_calc #(.LL_W(LL_W), .ML_W(ML_W)) u_calc (
    .skip   (skip_eff),
    .ll     (in_if.ll),
    .ml     (in_if.ml),
    .ll_out (t_ll),
    .ml_out (t_ml),
    .rem    (t_rem)
  );

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    emit    = 1'b0;
    set_err = 1'b0;
    if (in_fire) begin
      // Fully trimmed plain sequences vanish; markers (eoj/delim) survive.
      emit = (t_ll != '0) || (t_ml != '0) || in_if.eoj || in_if.delim;
      if (in_if.delim) begin
        skip_d  = '0;
        set_err = (t_rem != '0);
      end else if (in_if.eoj) begin
        // Leftover budget from this job is dropped, not carried into the next.
        skip_d  = in_if.overlap_len;
        set_err = (t_rem != '0);
      end else begin
        skip_d  = t_rem;
      end
      state_d = (skip_d != '0) ? ST_TRIM : ST_PASS;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_PASS;
      skip_q        <= '0;
      overlap_err   <= 1'b0;
      drop_cnt      <= '0;
      out_if.valid  <= 1'b0;
      out_if.ll     <= '0;
      out_if.ml     <= '0;
      out_if.offset <= '0;
      out_if.eoj    <= 1'b0;
      out_if.delim  <= 1'b0;
    end else begin
      state_q     <= state_d;
      skip_q      <= skip_d;
      overlap_err <= overlap_err | set_err;

      if (in_fire && !emit && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + 1'b1;
      end

      if (in_fire && emit) begin
        out_if.valid  <= 1'b1;
        out_if.ll     <= t_ll;
        out_if.ml     <= t_ml;
        out_if.offset <= in_if.offset;
        out_if.eoj    <= in_if.eoj;
        out_if.delim  <= in_if.delim;
      end else if (out_if.ready) begin
        out_if.valid  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/seq_overlap_trimmer.md
Name: seq_overlap_trimmer

Overview:
- Sits directly downstream of the job match PE cluster's seq output port, one instance per job PE.
- Successive jobs overlap in the input stream. The last sequence of a job (eoj=1) reports seq_overlap_len: the number of leading bytes of the next job that are already covered.
- This block removes those covered bytes from the head of the next job's sequences, so the downstream sequence encoder sees a contiguous, non-overlapping stream.
- One registered output stage with valid/ready flow control.

Parameters:
LL_W, `SEQ_LL_BITS, literal-length field width
ML_W, `SEQ_ML_BITS, match-length and overlap-length field width
OFF_W, `SEQ_OFFSET_BITS, offset field width
CNT_W, 16, width of drop counter

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
in_valid  in  1  input sequence valid
in_ll  in  LL_W  literal length
in_ml  in  ML_W  match length
in_offset  in  OFF_W  match offset
in_eoj  in  1  last sequence of a job
in_overlap_len  in  ML_W  bytes of next job already covered (meaningful only when in_eoj=1)
in_delim  in  1  block delimiter
in_ready  out  1  input accepted
out_valid  out  1  output sequence valid
out_ll  out  LL_W  trimmed literal length
out_ml  out  ML_W  trimmed match length
out_offset  out  OFF_W  offset, passed through unchanged
out_eoj  out  1  passed through
out_delim  out  1  passed through
out_ready  in  1  downstream ready
overlap_err  out  1  sticky flag: a job ended before its skip budget was consumed
drop_cnt  out  CNT_W  count of fully swallowed sequences, saturating

Behaviour:
- Clock and reset: one clock, clk. rst_n is synchronous and active-low.
- Reset values: out_valid=0, all out_* data fields=0, skip=0, state=PASS, overlap_err=0, drop_cnt=0.
- Reset mid-operation discards the held output and the skip budget.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Input fires when in_valid && in_ready.
  - Output fires when out_valid && out_ready.
  - Latency is 1 cycle from input fire to out_valid.
  - Output data is held stable while out_valid && !out_ready.
  - When both sides fire in the same cycle, the output register reloads. There is no bubble, so throughput is 1 sequence/cycle.
- State machine, over a skip register of ML_W bits:
  - PASS (skip==0): the sequence is forwarded unmodified.
  - TRIM (skip>0): trimming is applied on each input fire, in this order:
    - if skip <= ll: ll' = ll - skip, ml' = ml, rem = 0.
    - else: r = skip - ll, ll' = 0. Then if r < ml: ml' = ml - r, rem = 0; else ml' = 0, rem = r - ml.
- Emit rule:
  - If ll' == 0 and ml' == 0 and eoj == 0 and delim == 0: the sequence is swallowed. No output is produced, out_valid does not rise, in_ready behaves as above, and drop_cnt increments (saturating at all-ones).
  - Otherwise the sequence is emitted with ll', ml', offset, eoj and delim. A marker sequence whose lengths are both trimmed to zero is still emitted, with ll=0 and ml=0.
- Next-state rule, evaluated on input fire in priority order:
  - delim=1: skip <= 0, go to PASS. in_overlap_len is ignored. If rem > 0, set overlap_err.
  - eoj=1: skip <= in_overlap_len, go to TRIM if nonzero, else PASS. If rem > 0, set overlap_err; the residual is discarded, not accumulated.
  - otherwise: skip <= rem. Go to PASS when rem == 0.
- Arithmetic and flags:
  - ll and skip comparisons are zero-extended to max(LL_W, ML_W).
  - Results never go negative; the comparisons above guarantee this.
  - overlap_err clears only on reset.
- The first job after reset is never trimmed, because skip is 0.

Decomposition:
- Field widths come from parameters.vh macros; no new package entries. Add `SEQ_DROP_CNT_BITS = 16 to parameters.vh for CNT_W.
- Place the trim arithmetic in a combinational function inside the module.
- One natural sub-module: seq_trim_calc (pure combinational: skip, ll, ml in; ll', ml', rem out). It can be unit-tested standalone.

Test Plan:
- Pass-through: seqs {ll=5, ml=10, off=100}, {ll=3, ml=4, off=7, eoj=1, overlap=0}, out_ready=1 → identical outputs 1 cycle later, drop_cnt=0.
- Literal trim: eoj seq with overlap=3, then {ll=5, ml=8} → output {ll=2, ml=8}, state returns to PASS.
- Match trim: overlap=9, next {ll=4, ml=12, off=50} → {ll=0, ml=7, off=50}.
- Multi-seq swallow: overlap=20, next {ll=2, ml=6}, {ll=1, ml=4}, {ll=3, ml=10} → first two swallowed (drop_cnt=2), third emitted as {ll=0, ml=6}.
- Marker and error: overlap=30, next job's sole seq {ll=2, ml=5, eoj=1, overlap=4} → emitted {ll=0, ml=0, eoj=1}, overlap_err=1, next seq {ll=6} emitted as {ll=2}.
- Backpressure and delim: hold out_ready=0 for 5 cycles mid-stream → in_ready=0 and outputs stable. A delim seq after overlap=7 clears skip, so the next seq passes unmodified. Asserting rst_n=0 mid-stream clears out_valid, skip and drop_cnt on the next edge.
